// File: rtl/nios_mul_pkg.sv
// Shared definitions for the Nios II multiply sequencer: op encodings, FSM states
// and the shift applied to each 16x16 partial product.
package nios_mul_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULXUU = 2'b01,
        MUL_OP_MULXSU = 2'b10,
        MUL_OP_MULXSS = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FIX   = 3'd3,
        ST_RESP  = 3'd4
    } mul_state_e;

    localparam logic [5:0] SHIFT_LL = 6'd0;
    localparam logic [5:0] SHIFT_HL = 6'd16;
    localparam logic [5:0] SHIFT_LH = 6'd16;
    localparam logic [5:0] SHIFT_HH = 6'd32;

    // Partial index order is ll, hl, lh, hh.
    function automatic logic [5:0] partial_shift(input logic [1:0] idx);
        case (idx)
            2'd0:    return SHIFT_LL;
            2'd1:    return SHIFT_HL;
            2'd2:    return SHIFT_LH;
            default: return SHIFT_HH;
        endcase
    endfunction

endpackage

// File: rtl/nios_mul_seq_signfix.sv
// Converts the unsigned 64-bit product's high word into the signed/mixed high word
// by subtracting the two's-complement correction terms.
module nios_mul_seq_signfix
    import nios_mul_pkg::*;
(
    input  mul_op_e            op,
    input  logic [DATA_W-1:0]  src_a,
    input  logic [DATA_W-1:0]  src_b,
    input  logic [DATA_W-1:0]  acc_hi,
    output logic [DATA_W-1:0]  high
);

    logic [DATA_W-1:0] corr;

    always_comb begin
        corr = '0;
        case (op)
            MUL_OP_MULXSS: corr = (src_a[DATA_W-1] ? src_b : '0) + (src_b[DATA_W-1] ? src_a : '0);
            MUL_OP_MULXSU: corr = src_a[DATA_W-1] ? src_b : '0;
            default:       corr = '0;
        endcase
        high = acc_hi - corr;
    end

endmodule

// File: rtl/nios_mul_seq.sv
// Operand sequencer / result collector around the Nios II multiplier cell.
// Define NIOS_MUL_SEQ_MULX_EN to build the four-pass MULX high-word path.
module nios_mul_seq
    import nios_mul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    output logic [DATA_W-1:0] mul_src1,
    output logic [DATA_W-1:0] mul_src2,
    input  logic [DATA_W-1:0] mul_cell_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data
);

    mul_state_e state;

`ifdef NIOS_MUL_SEQ_MULX_EN
    mul_op_e             op;
    logic [1:0]          k;
    logic [1:0]          k_next;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] cell_ext;
    logic [DATA_W-1:0]   src_a;
    logic [DATA_W-1:0]   src_b;
    logic [DATA_W-1:0]   fixed_high;

    // Zero-extended 16-bit half; hi selects bits [31:16].
    function automatic logic [DATA_W-1:0] half_src(input logic [DATA_W-1:0] x, input logic hi);
        return hi ? {16'h0, x[31:16]} : {16'h0, x[15:0]};
    endfunction

    assign k_next   = k + 2'd1;
    assign cell_ext = {{DATA_W{1'b0}}, mul_cell_result};

    nios_mul_seq_signfix u_signfix (
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .acc_hi (acc[2*DATA_W-1:DATA_W]),
        .high   (fixed_high)
    );
`else
    logic unused_op;
    assign unused_op = ^req_op;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mul_src1   <= '0;
            mul_src2   <= '0;
`ifdef NIOS_MUL_SEQ_MULX_EN
            op         <= MUL_OP_MUL;
            k          <= '0;
            acc        <= '0;
            src_a      <= '0;
            src_b      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        state     <= ST_ISSUE;
`ifdef NIOS_MUL_SEQ_MULX_EN
                        op    <= mul_op_e'(req_op);
                        src_a <= req_src1;
                        src_b <= req_src2;
                        k     <= '0;
                        acc   <= '0;
                        if (mul_op_e'(req_op) == MUL_OP_MUL) begin
                            mul_src1 <= req_src1;
                            mul_src2 <= req_src2;
                        end else begin
                            mul_src1 <= half_src(req_src1, 1'b0);
                            mul_src2 <= half_src(req_src2, 1'b0);
                        end
`else
                        mul_src1 <= req_src1;
                        mul_src2 <= req_src2;
`endif
                    end
                end
                ST_ISSUE: begin
`ifdef NIOS_MUL_SEQ_MULX_EN
                    if (op == MUL_OP_MUL) begin
                        mul_src1 <= '0;
                        mul_src2 <= '0;
                        state    <= ST_DRAIN;
                    end else begin
                        // The cell result seen now belongs to the partial issued at k-1.
                        if (k != 2'd0)
                            acc <= acc + (cell_ext << partial_shift(k - 2'd1));
                        if (k == 2'd3) begin
                            mul_src1 <= '0;
                            mul_src2 <= '0;
                            state    <= ST_DRAIN;
                        end else begin
                            mul_src1 <= half_src(src_a, k_next[0]);
                            mul_src2 <= half_src(src_b, k_next[1]);
                            k        <= k_next;
                        end
                    end
`else
                    mul_src1 <= '0;
                    mul_src2 <= '0;
                    state    <= ST_DRAIN;
`endif
                end
                ST_DRAIN: begin
`ifdef NIOS_MUL_SEQ_MULX_EN
                    if (op == MUL_OP_MUL) begin
                        resp_data  <= mul_cell_result;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        acc   <= acc + (cell_ext << SHIFT_HH);
                        state <= ST_FIX;
                    end
`else
                    resp_data  <= mul_cell_result;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
`endif
                end
`ifdef NIOS_MUL_SEQ_MULX_EN
                ST_FIX: begin
                    resp_data  <= fixed_high;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
